// File: rtl/count_game_pkg.sv
// count_game_pkg
// Shared definitions for the count game scheduler:
//   state_t  - turn scheduler FSM states
//   MODE_*   - 2-bit counter control modes driven onto cnt_control
//   WHO_*    - winner encoding reported on the who output
package count_game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_SCORE,
    S_OVER
  } state_t;

  localparam logic [1:0] MODE_UP1 = 2'b00;
  localparam logic [1:0] MODE_UP2 = 2'b01;
  localparam logic [1:0] MODE_DN1 = 2'b10;
  localparam logic [1:0] MODE_DN2 = 2'b11;

  localparam logic [1:0] WHO_NONE = 2'b00;
  localparam logic [1:0] WHO_A    = 2'b01;
  localparam logic [1:0] WHO_B    = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter. The grant is combinational from req and the
// priority flag; the flag moves on advance so that, when both players are
// requesting, the player not granted last wins. After reset A has priority.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   req[1:0]  - requests (bit0 A, bit1 B)
//   advance   - the current grant is being taken; update priority
//   gnt[1:0]  - one-hot grant (zero when no request)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic prio_b;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_b ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Granting A hands priority to B for the next contested turn, and vice versa.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_b <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      prio_b <= gnt[0];
    end
  end

endmodule

// File: rtl/count_game_sched.sv
// count_game_sched
// Two-player turn scheduler for a shared counter game. A granted player has
// its initial value loaded into the counter, then the counter runs in that
// player's mode until it reaches COUNT_MAX_VALUE (hit, player scores), 0
// (miss, opponent scores) or RUN_CYCLES cycles elapse (timeout, no score).
// The first player to reach SCORE_MAX ends the game until restart.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   req[1:0]          - turn requests (bit0 A, bit1 B)
//   req_mode[3:0]     - counter mode per player ([1:0] A, [3:2] B)
//   req_init[2*CW-1:0]- initial count per player (low CW bits A)
//   restart           - leave the game-over state
//   cnt_value[CW-1:0] - current count from the shared counter
//   gnt[1:0]          - one-hot owner of the current turn
//   cnt_init, cnt_init_value, cnt_control, cnt_clear - counter drive
//   score_a, score_b  - saturating scores
//   busy, game_over, who - status
//   turns[7:0]        - turn counter, present only with COUNT_GAME_SCHED_STATS_EN
// All outputs are registered: each is written on the edge entering the state
// in which it must be visible.
module count_game_sched
  import count_game_pkg::*;
#(
  parameter int COUNT_MAX_VALUE = 15,
  parameter int RUN_CYCLES      = 8,
  parameter int SCORE_MAX       = 15,
  localparam int CW             = $clog2(COUNT_MAX_VALUE + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [3:0]      req_mode,
  input  logic [2*CW-1:0] req_init,
  input  logic            restart,
  input  logic [CW-1:0]   cnt_value,
  output logic [1:0]      gnt,
  output logic            cnt_init,
  output logic [CW-1:0]   cnt_init_value,
  output logic [1:0]      cnt_control,
  output logic            cnt_clear,
  output logic [3:0]      score_a,
  output logic [3:0]      score_b,
  output logic            busy,
  output logic            game_over,
  output logic [1:0]      who
`ifdef COUNT_GAME_SCHED_STATS_EN
  ,
  output logic [7:0]      turns
`endif
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(COUNT_MAX_VALUE);
  localparam logic [3:0]    SMAX     = 4'(SCORE_MAX);
  localparam logic [7:0]    RUN_LAST = 8'(RUN_CYCLES - 1);

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= SMAX) ? s : s + 4'd1;
  endfunction

  state_t      state;
  logic [1:0]  arb_gnt;
  logic        advance;
  logic [1:0]  mode_l;
  logic [7:0]  run_cnt;
  logic        hit;
  logic        miss;
  logic        timeout;

  assign advance = (state == S_IDLE) && (req != 2'b00);
  assign hit     = (cnt_value == CNT_MAX);
  assign miss    = (cnt_value == '0) && !hit;
  assign timeout = (run_cnt == RUN_LAST);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (advance),
    .gnt     (arb_gnt)
  );

  // Mode is data: latched at grant, never needs a reset value.
  always_ff @(posedge clk) begin
    if (advance) begin
      mode_l <= arb_gnt[1] ? req_mode[3:2] : req_mode[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      gnt            <= 2'b00;
      busy           <= 1'b0;
      score_a        <= 4'd0;
      score_b        <= 4'd0;
      who            <= WHO_NONE;
      game_over      <= 1'b0;
      cnt_init       <= 1'b0;
      cnt_init_value <= '0;
      cnt_control    <= MODE_UP1;
      cnt_clear      <= 1'b0;
      run_cnt        <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (advance) begin
            state          <= S_LOAD;
            gnt            <= arb_gnt;
            busy           <= 1'b1;
            cnt_init       <= 1'b1;
            cnt_init_value <= arb_gnt[1] ? req_init[2*CW-1:CW] : req_init[CW-1:0];
          end
        end
        S_LOAD: begin
          state       <= S_RUN;
          cnt_init    <= 1'b0;
          cnt_control <= mode_l;
          run_cnt     <= 8'd0;
        end
        S_RUN: begin
          // Scores update on the way into SCORE so the end-of-game test
          // in SCORE sees the new value.
          if (hit || miss || timeout) begin
            state       <= S_SCORE;
            cnt_control <= MODE_UP1;
            if (hit) begin
              if (gnt[0]) score_a <= sat_inc(score_a);
              else        score_b <= sat_inc(score_b);
            end else if (miss) begin
              if (gnt[0]) score_b <= sat_inc(score_b);
              else        score_a <= sat_inc(score_a);
            end
          end else begin
            run_cnt <= run_cnt + 8'd1;
          end
        end
        S_SCORE: begin
          gnt  <= 2'b00;
          busy <= 1'b0;
          if ((score_a == SMAX) || (score_b == SMAX)) begin
            state     <= S_OVER;
            game_over <= 1'b1;
            who       <= (score_a == SMAX) ? WHO_A : WHO_B;
            cnt_clear <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_OVER: begin
          cnt_clear <= 1'b0;
          if (restart) begin
            state     <= S_IDLE;
            score_a   <= 4'd0;
            score_b   <= 4'd0;
            who       <= WHO_NONE;
            game_over <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef COUNT_GAME_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || ((state == S_OVER) && restart)) begin
      turns <= 8'd0;
    end else if ((state == S_SCORE) && (turns != 8'hFF)) begin
      turns <= turns + 8'd1;
    end
  end
`endif

endmodule
